// File: rtl/uart_rx_core.sv
// uart_rx_core -- oversampled UART receive engine.
//
// Detects a start bit on the synchronized line, samples each bit at mid-bit,
// checks even/odd parity and 1 or 2 stop bits, flags break frames, and hands
// the result to a one-entry valid/ready holding register. A completed frame
// that arrives while the holding register is full and not being drained is
// dropped and reported with a one-clk overrun pulse.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN -- each bit is the 2-of-3
// vote of the samples at OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1, with
// the decision (and frame completion) taken at OVERSAMPLE/2+1.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rx_clk_en           oversample tick (OVERSAMPLE ticks per bit)
//   rx                  asynchronous serial input, idle high
//   data_bits           payload length, clamped to 5..MAX_DATA_BITS
//   parity_en/_odd      parity present / odd (1) or even (0)
//   double_stop_bit     two stop bits expected
//   out_valid/out_ready holding-register handshake
//   out_data            right-aligned payload, unused upper bits 0
//   parity_error, frame_error, break_detect  flags qualified by out_valid
//   overrun             one-clk pulse when a completed frame is dropped
module uart_rx_core #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_clk_en,
  input  logic                     rx,
  input  logic [3:0]               data_bits,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     double_stop_bit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MAX_DATA_BITS-1:0] out_data,
  output logic                     parity_error,
  output logic                     frame_error,
  output logic                     break_detect,
  output logic                     overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_C = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST_C = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    MAXB_C = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT
  } state_t;

  state_t state_q, state_d;

  logic                     rx_s1, rx_s2, rx_s3, fall_pend;
  logic [CW-1:0]            cnt;
  logic [3:0]               bit_idx, nbits_q, nbits_clamped;
  logic                     par_en_q, par_odd_q, dstop_q;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic                     par_acc, perr_q, ferr_q, brk_q, all_zero;
  logic                     fall, start_seen, in_frame, wrap_tick, last_data;
  logic                     samp_tick, samp_bit;
  logic                     frame_done, done_ferr, done_brk;

  assign fall       = rx_s3 & ~rx_s2;
  // A falling edge seen between ticks is remembered until the next tick.
  assign start_seen = fall | fall_pend;
  assign in_frame   = state_q inside {START, DATA, PARITY, STOP1, STOP2};
  assign wrap_tick  = rx_clk_en && in_frame && (cnt == LAST_C);
  assign last_data  = (bit_idx == nbits_q - 4'd1);

  always_comb begin
    if (data_bits < 4'd5)         nbits_clamped = 4'd5;
    else if (data_bits > MAXB_C)  nbits_clamped = MAXB_C;
    else                          nbits_clamped = data_bits;
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] PRE_C  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] POST_C = CW'(OVERSAMPLE / 2 + 1);
  logic vote_a, vote_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (rx_clk_en && in_frame) begin
      if (cnt == PRE_C)  vote_a <= rx_s2;
      if (cnt == HALF_C) vote_b <= rx_s2;
    end
  end

  assign samp_tick = rx_clk_en && in_frame && (cnt == POST_C);
  assign samp_bit  = (vote_a & vote_b) | (vote_a & rx_s2) | (vote_b & rx_s2);
`else
  assign samp_tick = rx_clk_en && in_frame && (cnt == HALF_C);
  assign samp_bit  = rx_s2;
`endif

  // Completion flags: STOP1 decides break; STOP2 reuses what STOP1 recorded.
  assign done_ferr = ferr_q | ~samp_bit;
  assign done_brk  = (state_q == STOP1) ? (all_zero & ~samp_bit) : brk_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE:   if (rx_clk_en && start_seen) state_d = START;
      START: begin
        if (samp_tick && samp_bit) state_d = IDLE;   // false start
        else if (wrap_tick)        state_d = DATA;
      end
      DATA:   if (wrap_tick && last_data) state_d = par_en_q ? PARITY : STOP1;
      PARITY: if (wrap_tick) state_d = STOP1;
      STOP1: begin
        if (samp_tick && !dstop_q) begin
          // Finish at mid-bit so a short stop bit can still resync.
          frame_done = 1'b1;
          state_d    = done_brk ? BREAK_WAIT : IDLE;
        end else if (wrap_tick) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (samp_tick) begin
          frame_done = 1'b1;
          state_d    = done_brk ? BREAK_WAIT : IDLE;
        end
      end
      BREAK_WAIT: if (rx_s2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      fall_pend <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      nbits_q   <= 4'd5;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      dstop_q   <= 1'b0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      all_zero  <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;

      if (state_q != IDLE || rx_s2 || rx_clk_en) fall_pend <= 1'b0;
      else if (fall)                              fall_pend <= 1'b1;

      if (state_q == IDLE && state_d == START) begin
        cnt       <= '0;
        nbits_q   <= nbits_clamped;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        dstop_q   <= double_stop_bit;
      end else if (rx_clk_en && in_frame) begin
        cnt <= wrap_tick ? '0 : cnt + 1'b1;
      end

      if (samp_tick) begin
        case (state_q)
          START: begin
            shreg    <= '0;
            bit_idx  <= '0;
            par_acc  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            all_zero <= 1'b1;
          end
          DATA: begin
            shreg[bit_idx] <= samp_bit;
            par_acc        <= par_acc ^ samp_bit;
            if (samp_bit) all_zero <= 1'b0;
          end
          PARITY: begin
            // Even: payload^parity must be 0; odd: must be 1.
            perr_q <= par_acc ^ samp_bit ^ par_odd_q;
            if (samp_bit) all_zero <= 1'b0;
          end
          STOP1: begin
            if (!samp_bit) ferr_q <= 1'b1;
            brk_q <= all_zero & ~samp_bit;
          end
          default: ;
        endcase
      end

      if (wrap_tick && state_q == DATA) bit_idx <= bit_idx + 4'd1;
    end
  end

  // Holding register: a full, undrained register keeps its frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      break_detect <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= frame_done && out_valid && !out_ready;
      if (frame_done && (!out_valid || out_ready)) begin
        out_valid    <= 1'b1;
        out_data     <= shreg;
        parity_error <= perr_q;
        frame_error  <= done_ferr;
        break_detect <= done_brk;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine: oversampled start-bit detection, runtime-selectable 5..MAX_DATA_BITS data width, even/odd parity, 1 or 2 stop bits, break detection and a one-entry valid/ready output holding register with overrun reporting. It sits between the pad-side RX pin and the RX queue of the UART peripheral. It replaces the split controller/datapath RX arrangement with a single self-contained block.

## Interface
- MAX_DATA_BITS, 9: widest supported frame payload; legal range 5..9.
- OVERSAMPLE, 16: rx_clk_en ticks per bit; even, at least 8.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- rx_clk_en  in  1  oversample tick, one clk wide.
- rx  in  1  asynchronous serial input, idle high.
- data_bits  in  4  payload length; values below 5 act as 5, values above MAX_DATA_BITS act as MAX_DATA_BITS.
- parity_en  in  1  parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- double_stop_bit  in  1  two stop bits expected.
- out_valid  out  1  holding register full.
- out_ready  in  1  consumer accepts the held frame.
- out_data  out  MAX_DATA_BITS  payload, LSB-first on the line, right-aligned, unused upper bits 0.
- parity_error  out  1  parity mismatch; qualified by out_valid.
- frame_error  out  1  a stop bit was sampled low; qualified by out_valid.
- break_detect  out  1  break frame; qualified by out_valid.
- overrun  out  1  one-clk pulse: a completed frame was dropped.

## Operation
- rx passes a 2-FF synchronizer, reset value 1. Falling edge is detected on the synchronized value.
- Sample counter runs 0..OVERSAMPLE-1 and advances only on rx_clk_en. The mid-bit sample point is OVERSAMPLE/2. At OVERSAMPLE-1 the counter wraps to 0 and the FSM advances to the next bit.
- data_bits, parity_en, parity_odd and double_stop_bit are latched at start-edge detection and held for the whole frame.
- FSM states:
  - IDLE: on falling edge, clear the sample counter and go to START.
  - START: at mid-bit, sampled 1 = false start, return to IDLE with no output. Sampled 0 = clear shift register and parity accumulator.
  - DATA: sample each bit at mid-bit, LSB first. Leave after the latched data_bits count.
  - PARITY: entered only if parity_en. Checks even parity (payload XOR parity bit == 0) or odd parity (== 1).
  - STOP1: sampled at mid-bit.
  - STOP2: entered only if double_stop_bit.
  - BREAK_WAIT: hold until synchronized rx is 1, then go to IDLE.
- The frame completes at the mid-bit sample of the last stop bit. The FSM then goes to IDLE immediately, which permits resynchronisation on a short stop bit.
- frame_error is set if any stop bit samples 0.
- break_detect is set if all payload bits, the parity bit (when present) and STOP1 are all 0. A break frame is delivered with frame_error=1 and break_detect=1, and the FSM enters BREAK_WAIT instead of IDLE.
- Holding register, frame-complete behaviour:
  - out_valid=0, or out_valid && out_ready in the same cycle: load data and flags, out_valid=1.
  - out_valid && !out_ready: keep the old frame, drop the new one, pulse overrun.
- Handshake: out_valid && out_ready with no frame completion clears out_valid on the next clk.

## Timing
- Reset (any time, including mid-frame) gives: state IDLE, out_valid=0, out_data=0, all error flags 0, overrun=0, synchronizer=1. Any partial frame is discarded.
- Synchronizer latency is 2 clk. Start is detected on the first rx_clk_en after the synchronized falling edge.
- out_valid, out_data and the flags are registered. They rise 1 clk after the rx_clk_en tick carrying the final stop-bit sample.
- overrun is high for exactly 1 clk, aligned with the cycle out_valid would have been loaded.
- Output handshake is independent of rx_clk_en. out_data and the flags are stable while out_valid=1.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: each bit value, including START, is the 2-of-3 majority of the samples at OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit decision is taken at OVERSAMPLE/2+1, and frame completion moves to that tick.
- Not defined: single sample at OVERSAMPLE/2; no vote registers.

## Test plan
All scenarios use OVERSAMPLE=16, rx_clk_en every clk, MAX_DATA_BITS=9.
- 8N1, byte 0xA5, out_ready=1 -> out_valid pulse with out_data=0x0A5, all flags 0.
- 7E2, payload 0x35 sent with a wrong parity bit -> out_data=0x35, parity_error=1, frame_error=0. Repeat with STOP2 low -> frame_error=1.
- 9-bit odd parity, payload 0x1FF -> out_data=0x1FF, parity_error=0. With data_bits=3, 5 bits are received.
- Low glitch of 4 clk on idle line -> false start, no out_valid, FSM back in IDLE.
- Line held low for 40 bit times, 8N1 -> one frame with out_data=0, break_detect=1, frame_error=1, then no further frames until rx returns high.
- out_ready=0, two back-to-back frames 0x11 then 0x22 -> out_data stays 0x11, overrun pulses once. Reset mid-third-frame -> out_valid=0, next clean frame received correctly.
